// File: rtl/mem_stage_pkg.sv
// Shared encodings for the memory-access stage: exception codes and FSM states.
package mem_stage_pkg;

    // Writeback exception codes
    localparam logic [1:0] EXC_NONE  = 2'd0;
    localparam logic [1:0] EXC_OVF   = 2'd1;
    localparam logic [1:0] EXC_ALIGN = 2'd2;
    localparam logic [1:0] EXC_BUS   = 2'd3;

    typedef enum logic {
        StIdle = 1'b0,
        StBus  = 1'b1
    } mem_state_e;

    // Word accesses must have the two low address bits clear
    function automatic logic is_misaligned(input logic [31:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/mem_timeout_ctr.sv
// Saturating wait-state counter. Flags expiry on the last allowed enabled cycle.
module mem_timeout_ctr #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    input  logic i_en,
    output logic o_expire
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] MAX  = CW'(TIMEOUT);

    logic [CW-1:0] r_count;
    logic [CW-1:0] w_count_d;

    // Next count: clear wins, otherwise count enabled cycles up to saturation
    always_comb begin
        w_count_d = r_count;
        if (i_clear) begin
            w_count_d = '0;
        end else if (i_en && (r_count != MAX)) begin
            w_count_d = r_count + 1'b1;
        end
    end

    // Count register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else begin
            r_count <= w_count_d;
        end
    end

    // This enabled cycle is the TIMEOUT-th without completion
    assign o_expire = i_en && (r_count >= LAST);

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: registers execute results, runs LW/SW over a req/ack port and
// emits one writeback bundle per accepted instruction.
module mem_stage #(
    parameter int unsigned TIMEOUT     = 16,
    parameter bit          CHECK_ALIGN = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_in_valid,
    output logic        o_in_ready,
    input  logic [31:0] i_alu_result,
    input  logic [4:0]  i_alu_reg_addr,
    input  logic        i_alu_read,
    input  logic        i_alu_write,
    input  logic        i_alu_excp,
    input  logic [31:0] i_store_data,
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    input  logic [31:0] i_mem_rdata,
    input  logic        i_mem_ack,
    output logic        o_wb_valid,
    output logic        o_wb_en,
    output logic [4:0]  o_wb_addr,
    output logic [31:0] o_wb_data,
    output logic [1:0]  o_wb_excp,
    output logic        o_busy
);

    import mem_stage_pkg::*;

    mem_state_e  r_state, w_state_d;

    logic [31:0] r_mem_addr, w_mem_addr_d;
    logic [31:0] r_mem_wdata, w_mem_wdata_d;
    logic        r_mem_we, w_mem_we_d;
    logic [4:0]  r_mem_reg, w_mem_reg_d;

    logic        r_wb_valid, w_wb_valid_d;
    logic        r_wb_en, w_wb_en_d;
    logic [4:0]  r_wb_addr, w_wb_addr_d;
    logic [31:0] r_wb_data, w_wb_data_d;
    logic [1:0]  r_wb_excp, w_wb_excp_d;

    logic        w_accept;
    logic        w_is_mem;
    logic        w_illegal;
    logic        w_ctr_clear;
    logic        w_ctr_en;
    logic        w_expire;

    assign o_in_ready = (r_state == StIdle);
    assign o_busy     = ~o_in_ready;
    assign w_accept   = i_in_valid && o_in_ready;
    assign w_is_mem   = i_alu_read || i_alu_write;
    assign w_illegal  = (i_alu_read && i_alu_write) ||
                        (CHECK_ALIGN && w_is_mem && is_misaligned(i_alu_result));

    mem_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout_ctr (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_clear  (w_ctr_clear),
        .i_en     (w_ctr_en),
        .o_expire (w_expire)
    );

    // Next-state, bus latches and writeback bundle; accept priority is
    // overflow > illegal/misaligned > memory op > plain result
    always_comb begin
        w_state_d     = r_state;
        w_mem_addr_d  = r_mem_addr;
        w_mem_wdata_d = r_mem_wdata;
        w_mem_we_d    = r_mem_we;
        w_mem_reg_d   = r_mem_reg;
        w_wb_valid_d  = 1'b0;
        w_wb_en_d     = r_wb_en;
        w_wb_addr_d   = r_wb_addr;
        w_wb_data_d   = r_wb_data;
        w_wb_excp_d   = r_wb_excp;
        w_ctr_clear   = 1'b0;
        w_ctr_en      = 1'b0;

        case (r_state)
            StIdle: begin
                if (w_accept) begin
                    if (i_alu_excp) begin
                        w_wb_valid_d = 1'b1;
                        w_wb_en_d    = 1'b0;
                        w_wb_addr_d  = i_alu_reg_addr;
                        w_wb_data_d  = i_alu_result;
                        w_wb_excp_d  = EXC_OVF;
                    end else if (w_illegal) begin
                        w_wb_valid_d = 1'b1;
                        w_wb_en_d    = 1'b0;
                        w_wb_addr_d  = i_alu_reg_addr;
                        w_wb_data_d  = i_alu_result;
                        w_wb_excp_d  = EXC_ALIGN;
                    end else if (w_is_mem) begin
                        w_state_d     = StBus;
                        w_mem_addr_d  = {i_alu_result[31:2], 2'b00};
                        w_mem_wdata_d = i_store_data;
                        w_mem_we_d    = i_alu_write;
                        w_mem_reg_d   = i_alu_reg_addr;
                        w_ctr_clear   = 1'b1;
                    end else begin
                        w_wb_valid_d = 1'b1;
                        w_wb_en_d    = (i_alu_reg_addr != 5'd0);
                        w_wb_addr_d  = i_alu_reg_addr;
                        w_wb_data_d  = i_alu_result;
                        w_wb_excp_d  = EXC_NONE;
                    end
                end
            end
            StBus: begin
                w_ctr_en = ~i_mem_ack;
                // Ack on the final allowed cycle still completes normally
                if (i_mem_ack) begin
                    w_state_d    = StIdle;
                    w_wb_valid_d = 1'b1;
                    w_wb_addr_d  = r_mem_reg;
                    w_wb_excp_d  = EXC_NONE;
                    if (r_mem_we) begin
                        w_wb_en_d   = 1'b0;
                        w_wb_data_d = 32'd0;
                    end else begin
                        w_wb_en_d   = (r_mem_reg != 5'd0);
                        w_wb_data_d = i_mem_rdata;
                    end
                end else if (w_expire) begin
                    w_state_d    = StIdle;
                    w_wb_valid_d = 1'b1;
                    w_wb_en_d    = 1'b0;
                    w_wb_addr_d  = r_mem_reg;
                    w_wb_data_d  = r_mem_addr;
                    w_wb_excp_d  = EXC_BUS;
                end
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    // State, bus latches and writeback registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= StIdle;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_we    <= 1'b0;
            r_mem_reg   <= '0;
            r_wb_valid  <= 1'b0;
            r_wb_en     <= 1'b0;
            r_wb_addr   <= '0;
            r_wb_data   <= '0;
            r_wb_excp   <= EXC_NONE;
        end else begin
            r_state     <= w_state_d;
            r_mem_addr  <= w_mem_addr_d;
            r_mem_wdata <= w_mem_wdata_d;
            r_mem_we    <= w_mem_we_d;
            r_mem_reg   <= w_mem_reg_d;
            r_wb_valid  <= w_wb_valid_d;
            r_wb_en     <= w_wb_en_d;
            r_wb_addr   <= w_wb_addr_d;
            r_wb_data   <= w_wb_data_d;
            r_wb_excp   <= w_wb_excp_d;
        end
    end

    // Request follows state directly so reset drops it without waiting for a clock
    assign o_mem_req   = (r_state == StBus);
    assign o_mem_we    = r_mem_we;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wdata = r_mem_wdata;
    assign o_wb_valid  = r_wb_valid;
    assign o_wb_en     = r_wb_en;
    assign o_wb_addr   = r_wb_addr;
    assign o_wb_data   = r_wb_data;
    assign o_wb_excp   = r_wb_excp;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: scenario tasks with hand-computed expectations.
module tb_mem_stage;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] alu_result;
    logic [4:0]  alu_reg_addr;
    logic        alu_read;
    logic        alu_write;
    logic        alu_excp;
    logic [31:0] store_data;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        wb_valid;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic [1:0]  wb_excp;
    logic        busy;

    int n_vec;
    int n_err;

    mem_stage #(
        .TIMEOUT     (16),
        .CHECK_ALIGN (1'b1)
    ) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_in_valid     (in_valid),
        .o_in_ready     (in_ready),
        .i_alu_result   (alu_result),
        .i_alu_reg_addr (alu_reg_addr),
        .i_alu_read     (alu_read),
        .i_alu_write    (alu_write),
        .i_alu_excp     (alu_excp),
        .i_store_data   (store_data),
        .o_mem_req      (mem_req),
        .o_mem_we       (mem_we),
        .o_mem_addr     (mem_addr),
        .o_mem_wdata    (mem_wdata),
        .i_mem_rdata    (mem_rdata),
        .i_mem_ack      (mem_ack),
        .o_wb_valid     (wb_valid),
        .o_wb_en        (wb_en),
        .o_wb_addr      (wb_addr),
        .o_wb_data      (wb_data),
        .o_wb_excp      (wb_excp),
        .o_busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge
    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] res, input logic [4:0] rd,
                         input logic rd_en, input logic wr_en, input logic ex,
                         input logic [31:0] sd);
        in_valid     = v;
        alu_result   = res;
        alu_reg_addr = rd;
        alu_read     = rd_en;
        alu_write    = wr_en;
        alu_excp     = ex;
        store_data   = sd;
    endtask

    task automatic test_reset;
        n_vec++;
        if ({mem_req, mem_we, wb_valid, wb_en, wb_excp} !== 6'b0) begin
            n_err++;
            $display("FAIL reset_ctrl: got req=%b we=%b wbv=%b wben=%b excp=%0d, want all 0",
                     mem_req, mem_we, wb_valid, wb_en, wb_excp);
        end
        n_vec++;
        if ({mem_addr, mem_wdata, wb_addr, wb_data} !== 101'b0) begin
            n_err++;
            $display("FAIL reset_data: got addr=%h wdata=%h wba=%0d wbd=%h, want 0",
                     mem_addr, mem_wdata, wb_addr, wb_data);
        end
        n_vec++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_ready: got ready=%b busy=%b, want 1/0", in_ready, busy);
        end
    endtask

    task automatic test_back_to_back;
        drive(1'b1, 32'h1234, 5'd5, 1'b0, 1'b0, 1'b0, 32'h0);
        cyc();
        n_vec++;
        if (wb_valid !== 1'b1 || wb_data !== 32'h1234 || wb_en !== 1'b1 || wb_addr !== 5'd5
            || wb_excp !== 2'd0) begin
            n_err++;
            $display("FAIL b2b_first: got v=%b d=%h en=%b a=%0d x=%0d, want 1 1234 1 5 0",
                     wb_valid, wb_data, wb_en, wb_addr, wb_excp);
        end
        n_vec++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_ready: got %b want 1", in_ready);
        end
        alu_reg_addr = 5'd0;
        cyc();
        n_vec++;
        if (wb_valid !== 1'b1 || wb_data !== 32'h1234 || wb_en !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_second: got v=%b d=%h en=%b, want 1 1234 0",
                     wb_valid, wb_data, wb_en);
        end
        in_valid = 1'b0;
        cyc();
        n_vec++;
        if (wb_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_pulse: got v=%b ready=%b, want 0 1", wb_valid, in_ready);
        end
    endtask

    task automatic test_load_wait;
        drive(1'b1, 32'h100, 5'd8, 1'b1, 1'b0, 1'b0, 32'h0);
        cyc();
        // Scramble execute inputs: bus outputs must stay latched
        drive(1'b1, 32'hFFFF_FFF0, 5'd1, 1'b0, 1'b0, 1'b0, 32'h0);
        n_vec++;
        if (mem_addr !== 32'h100 || mem_we !== 1'b0) begin
            n_err++;
            $display("FAIL lw_addr: got addr=%h we=%b, want 100 0", mem_addr, mem_we);
        end
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (mem_req !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1 || wb_valid !== 1'b0
                || mem_addr !== 32'h100) begin
                n_err++;
                $display("FAIL lw_wait%0d: got req=%b ready=%b busy=%b v=%b addr=%h", i,
                         mem_req, in_ready, busy, wb_valid, mem_addr);
            end
            if (i == 3) begin
                mem_ack   = 1'b1;
                mem_rdata = 32'hDEAD_BEEF;
            end
            cyc();
        end
        mem_ack  = 1'b0;
        in_valid = 1'b0;
        n_vec++;
        if (mem_req !== 1'b0 || wb_valid !== 1'b1 || wb_data !== 32'hDEAD_BEEF || wb_en !== 1'b1
            || wb_addr !== 5'd8 || wb_excp !== 2'd0) begin
            n_err++;
            $display("FAIL lw_done: got req=%b v=%b d=%h en=%b a=%0d x=%0d", mem_req,
                     wb_valid, wb_data, wb_en, wb_addr, wb_excp);
        end
        cyc();
        n_vec++;
        if (wb_valid !== 1'b0) begin
            n_err++;
            $display("FAIL lw_pulse: got v=%b want 0", wb_valid);
        end
    endtask

    task automatic test_store;
        drive(1'b1, 32'h204, 5'd3, 1'b0, 1'b1, 1'b0, 32'hA5A5_A5A5);
        cyc();
        in_valid = 1'b0;
        n_vec++;
        if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_wdata !== 32'hA5A5_A5A5
            || mem_addr !== 32'h204) begin
            n_err++;
            $display("FAIL sw_bus: got req=%b we=%b wd=%h addr=%h", mem_req, mem_we,
                     mem_wdata, mem_addr);
        end
        mem_ack = 1'b1;
        cyc();
        mem_ack = 1'b0;
        n_vec++;
        if (wb_valid !== 1'b1 || wb_en !== 1'b0 || wb_excp !== 2'd0 || wb_data !== 32'd0
            || mem_req !== 1'b0) begin
            n_err++;
            $display("FAIL sw_done: got v=%b en=%b x=%0d d=%h req=%b", wb_valid, wb_en,
                     wb_excp, wb_data, mem_req);
        end
    endtask

    task automatic test_exceptions;
        // Misaligned load
        drive(1'b1, 32'h102, 5'd4, 1'b1, 1'b0, 1'b0, 32'h0);
        cyc();
        n_vec++;
        if (mem_req !== 1'b0 || wb_valid !== 1'b1 || wb_excp !== 2'd2 || wb_en !== 1'b0
            || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL misalign: got req=%b v=%b x=%0d en=%b ready=%b", mem_req,
                     wb_valid, wb_excp, wb_en, in_ready);
        end
        // Read and write together
        drive(1'b1, 32'h200, 5'd4, 1'b1, 1'b1, 1'b0, 32'h0);
        cyc();
        n_vec++;
        if (mem_req !== 1'b0 || wb_valid !== 1'b1 || wb_excp !== 2'd2 || wb_en !== 1'b0) begin
            n_err++;
            $display("FAIL rd_wr: got req=%b v=%b x=%0d en=%b", mem_req, wb_valid,
                     wb_excp, wb_en);
        end
        // Overflow outranks a (misaligned) load
        drive(1'b1, 32'h301, 5'd4, 1'b1, 1'b0, 1'b1, 32'h0);
        cyc();
        in_valid = 1'b0;
        alu_excp = 1'b0;
        n_vec++;
        if (mem_req !== 1'b0 || wb_valid !== 1'b1 || wb_excp !== 2'd1 || wb_en !== 1'b0) begin
            n_err++;
            $display("FAIL ovf: got req=%b v=%b x=%0d en=%b", mem_req, wb_valid,
                     wb_excp, wb_en);
        end
        cyc();
        n_vec++;
        if (mem_req !== 1'b0 || wb_valid !== 1'b0) begin
            n_err++;
            $display("FAIL exc_quiet: got req=%b v=%b want 0 0", mem_req, wb_valid);
        end
    endtask

    task automatic test_timeout;
        int n;
        drive(1'b1, 32'h400, 5'd9, 1'b1, 1'b0, 1'b0, 32'h0);
        cyc();
        in_valid = 1'b0;
        n = 0;
        while (mem_req === 1'b1 && n < 40) begin
            n++;
            cyc();
        end
        n_vec++;
        if (n !== 16) begin
            n_err++;
            $display("FAIL to_req_cycles: got %0d want 16", n);
        end
        n_vec++;
        if (wb_valid !== 1'b1 || wb_excp !== 2'd3 || wb_en !== 1'b0) begin
            n_err++;
            $display("FAIL to_excp: got v=%b x=%0d en=%b want 1 3 0", wb_valid, wb_excp, wb_en);
        end
        // Ack on the 16th request cycle completes normally
        drive(1'b1, 32'h404, 5'd9, 1'b1, 1'b0, 1'b0, 32'h0);
        cyc();
        in_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            n_vec++;
            if (mem_req !== 1'b1 || wb_valid !== 1'b0) begin
                n_err++;
                $display("FAIL to_edge_wait%0d: got req=%b v=%b want 1 0", i, mem_req, wb_valid);
            end
            if (i == 15) begin
                mem_ack   = 1'b1;
                mem_rdata = 32'h600D_F00D;
            end
            cyc();
        end
        mem_ack = 1'b0;
        n_vec++;
        if (wb_valid !== 1'b1 || wb_excp !== 2'd0 || wb_data !== 32'h600D_F00D
            || wb_en !== 1'b1 || mem_req !== 1'b0) begin
            n_err++;
            $display("FAIL to_edge_ack: got v=%b x=%0d d=%h en=%b req=%b", wb_valid,
                     wb_excp, wb_data, wb_en, mem_req);
        end
    endtask

    task automatic test_reset_mid_bus;
        drive(1'b1, 32'h500, 5'd10, 1'b1, 1'b0, 1'b0, 32'h0);
        cyc();
        in_valid = 1'b0;
        cyc();
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (mem_req !== 1'b0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL rst_async: got req=%b ready=%b want 0 1", mem_req, in_ready);
        end
        mem_ack   = 1'b1;
        mem_rdata = 32'hBAD0_BAD0;
        cyc();
        mem_ack = 1'b0;
        #2;
        rst_n = 1'b1;
        cyc();
        n_vec++;
        if (wb_valid !== 1'b0 || mem_req !== 1'b0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL rst_lost: got v=%b req=%b ready=%b want 0 0 1", wb_valid,
                     mem_req, in_ready);
        end
        drive(1'b1, 32'h600, 5'd11, 1'b1, 1'b0, 1'b0, 32'h0);
        cyc();
        in_valid = 1'b0;
        n_vec++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h600) begin
            n_err++;
            $display("FAIL rst_relw_req: got req=%b addr=%h want 1 600", mem_req, mem_addr);
        end
        mem_ack   = 1'b1;
        mem_rdata = 32'h1234_5678;
        cyc();
        mem_ack = 1'b0;
        n_vec++;
        if (wb_valid !== 1'b1 || wb_data !== 32'h1234_5678 || wb_en !== 1'b1
            || wb_addr !== 5'd11 || wb_excp !== 2'd0) begin
            n_err++;
            $display("FAIL rst_relw_done: got v=%b d=%h en=%b a=%0d x=%0d", wb_valid,
                     wb_data, wb_en, wb_addr, wb_excp);
        end
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        rst_n     = 1'b0;
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0);
        #3;
        test_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        cyc();
        test_back_to_back();
        test_load_wait();
        test_store();
        test_exceptions();
        test_timeout();
        test_reset_mid_bus();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1);
    end

endmodule
